freq_sweep_ctrl: RTL and testbench

FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

---
 rtl/freq_sweep_ctrl_if.sv | 29 ++
 rtl/freq_sweep_ctrl.sv | 141 ++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/freq_sweep_ctrl_if.sv
// Control/status bundle between a sweep master and freq_sweep_ctrl.
// Clk and Resetn stay outside the bundle as plain ports.
interface freq_sweep_ctrl_if #(
   parameter int unsigned CNT_W = 8
);
   logic             Start;
   logic             Abort;
   logic [3:0]       Sel_start;
   logic [3:0]       Sel_stop;
   logic [CNT_W-1:0] Settle;
   logic [CNT_W-1:0] Meas;
   logic             Fout;
   logic [3:0]       Fsel;
   logic             Div_resetn;
   logic             Meas_en;
   logic             Step_done;
   logic             Busy;
   logic             Done;

   modport slave (
      input  Start, Abort, Sel_start, Sel_stop, Settle, Meas, Fout,
      output Fsel, Div_resetn, Meas_en, Step_done, Busy, Done
   );

   modport master (
      output Start, Abort, Sel_start, Sel_stop, Settle, Meas, Fout,
      input  Fsel, Div_resetn, Meas_en, Step_done, Busy, Done
   );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Steps a divider select from a start to a stop value, settling and measuring Fout at each step.
// Optional macro FSWEEP_BIDIR_EN enables descending sweeps (Sel_stop < Sel_start).
module freq_sweep_ctrl #(
   parameter int unsigned CNT_W = 8
) (
   input logic              Clk,
   input logic              Resetn,
   freq_sweep_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StSettle,
      StMeasure,
      StNext,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       fsel_q, fsel_d;
   logic [3:0]       stop_q, stop_d;
   logic [CNT_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0] meas_q, meas_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_rst_n_q, div_rst_n_d;
   logic             fout_q;

   logic [CNT_W-1:0] settle_tgt;
   logic [CNT_W-1:0] meas_tgt;
   logic             fout_rise;

   assign settle_tgt = (settle_q == '0) ? CNT_W'(1) : settle_q;
   assign meas_tgt   = (meas_q == '0) ? CNT_W'(1) : meas_q;
   assign fout_rise  = bus.Fout & ~fout_q;

   always_comb begin
      state_d     = state_q;
      fsel_d      = fsel_q;
      stop_d      = stop_q;
      settle_d    = settle_q;
      meas_d      = meas_q;
      cnt_d       = cnt_q;
      div_rst_n_d = 1'b1;

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.Start) begin
               fsel_d      = bus.Sel_start;
               stop_d      = bus.Sel_stop;
               settle_d    = bus.Settle;
               meas_d      = bus.Meas;
               div_rst_n_d = 1'b0;
               state_d     = StLoad;
            end
         end
         StLoad: begin
            cnt_d   = '0;
            state_d = StSettle;
         end
         StSettle: begin
            if (cnt_q >= settle_tgt - CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = StMeasure;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StMeasure: begin
            if (fout_rise) begin
               if (cnt_q >= meas_tgt - CNT_W'(1)) begin
                  state_d = StNext;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         StNext: begin
            cnt_d = '0;
            if (fsel_q == stop_q) begin
               state_d = StDone;
            end else if (stop_q > fsel_q) begin
               fsel_d      = fsel_q + 4'd1;
               div_rst_n_d = 1'b0;
               state_d     = StSettle;
            end else begin
`ifdef FSWEEP_BIDIR_EN
               fsel_d      = fsel_q - 4'd1;
               div_rst_n_d = 1'b0;
               state_d     = StSettle;
`else
               state_d     = StDone;
`endif
            end
         end
         default: state_d = StIdle;
      endcase

      // Abort outranks everything, including a same-cycle Start.
      if (bus.Abort) begin
         state_d     = StIdle;
         fsel_d      = fsel_q;
         stop_d      = stop_q;
         settle_d    = settle_q;
         meas_d      = meas_q;
         cnt_d       = '0;
         div_rst_n_d = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q     <= StIdle;
         fsel_q      <= 4'd0;
         stop_q      <= 4'd0;
         settle_q    <= '0;
         meas_q      <= '0;
         cnt_q       <= '0;
         div_rst_n_q <= 1'b0;
         fout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         fsel_q      <= fsel_d;
         stop_q      <= stop_d;
         settle_q    <= settle_d;
         meas_q      <= meas_d;
         cnt_q       <= cnt_d;
         div_rst_n_q <= div_rst_n_d;
         fout_q      <= bus.Fout;
      end
   end

   assign bus.Fsel       = fsel_q;
   assign bus.Div_resetn = div_rst_n_q;
   assign bus.Meas_en    = (state_q == StMeasure);
   assign bus.Step_done  = (state_q == StNext);
   assign bus.Busy       = (state_q == StLoad) || (state_q == StSettle) ||
                           (state_q == StMeasure) || (state_q == StNext);
   assign bus.Done       = (state_q == StDone);

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl with a behavioural 2^Fsel divider model.
module tb_freq_sweep_ctrl;

   logic Clk = 1'b0;
   logic Resetn;
   int   vectors = 0;
   int   miscompares = 0;

   freq_sweep_ctrl_if #(.CNT_W(8)) bus ();

   freq_sweep_ctrl #(.CNT_W(8)) dut (
      .Clk    (Clk),
      .Resetn (Resetn),
      .bus    (bus)
   );

   always #5 Clk = ~Clk;

   // Divider: period 2^Fsel (Fsel=0 approximated by period 2), held in reset by Div_resetn.
   logic [15:0] dcnt;
   always @(posedge Clk) begin
      if (!bus.Div_resetn) dcnt <= 16'd0;
      else dcnt <= dcnt + 16'd1;
   end
   assign bus.Fout = (bus.Fsel == 4'd0) ? dcnt[0] : dcnt[bus.Fsel - 4'd1];

   task automatic test_reset();
      Resetn        = 1'b0;
      bus.Start     = 1'b0;
      bus.Abort     = 1'b0;
      bus.Sel_start = 4'd0;
      bus.Sel_stop  = 4'd0;
      bus.Settle    = 8'd0;
      bus.Meas      = 8'd0;
      repeat (3) @(negedge Clk);
      vectors++;
      if ({bus.Fsel, bus.Div_resetn, bus.Meas_en, bus.Step_done, bus.Busy, bus.Done} !== 9'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got=%b want=0", {bus.Fsel, bus.Div_resetn, bus.Meas_en,
                  bus.Step_done, bus.Busy, bus.Done});
      end
      Resetn = 1'b1;
      @(negedge Clk);
      vectors++;
      if (bus.Div_resetn !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_divrst got=%b want=1", bus.Div_resetn);
      end
   endtask

   task automatic test_sweep(input string name, input int s0, input int s1, input int st,
                             input int ms);
      int   exp_q[$];
      int   steps, divlow, edges, gap, budget, settle_t, meas_t, last_fsel;
      logic prev_fout, prev_meas, last_edge;
      settle_t = (st == 0) ? 1 : st;
      meas_t   = (ms == 0) ? 1 : ms;
      if (s0 <= s1) begin
         for (int i = s0; i <= s1; i++) exp_q.push_back(i);
      end else begin
`ifdef FSWEEP_BIDIR_EN
         for (int i = s0; i >= s1; i--) exp_q.push_back(i);
`else
         exp_q.push_back(s0);
`endif
      end

      @(negedge Clk);
      bus.Sel_start = 4'(s0);
      bus.Sel_stop  = 4'(s1);
      bus.Settle    = 8'(st);
      bus.Meas      = 8'(ms);
      bus.Start     = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
      vectors++;
      if ({bus.Busy, bus.Done, bus.Div_resetn, bus.Fsel} !== {3'b100, 4'(s0)}) begin
         miscompares++;
         $display("FAIL %s_load got busy/done/divrst/fsel=%b want=%b", name,
                  {bus.Busy, bus.Done, bus.Div_resetn, bus.Fsel}, {3'b100, 4'(s0)});
      end

      divlow = 1; gap = 1; steps = 0; edges = 0; budget = 0; last_fsel = s0;
      prev_fout = bus.Fout; prev_meas = 1'b0; last_edge = 1'b0;
      while (bus.Done !== 1'b1 && budget < 40000) begin
         @(negedge Clk);
         budget++;
         if (int'(bus.Fsel) != last_fsel) begin
            vectors++;
            if (bus.Div_resetn !== 1'b0) begin
               miscompares++;
               $display("FAIL %s_fsel_change_divrst got=%b want=0", name, bus.Div_resetn);
            end
            last_fsel = int'(bus.Fsel);
         end
         if (!bus.Div_resetn) divlow++;
         if (bus.Step_done) begin
            vectors++;
            if (steps >= exp_q.size() || int'(bus.Fsel) != exp_q[steps] || edges != meas_t ||
                !last_edge) begin
               miscompares++;
               $display("FAIL %s_step%0d got fsel=%0d edges=%0d exit_after_edge=%b want fsel=%0d edges=%0d exit_after_edge=1",
                        name, steps, bus.Fsel, edges, last_edge,
                        (steps < exp_q.size()) ? exp_q[steps] : -1, meas_t);
            end
            steps++; gap = 0; edges = 0;
         end else if (bus.Meas_en) begin
            if (!prev_meas) begin
               vectors++;
               if (gap != ((steps == 0) ? settle_t + 1 : settle_t)) begin
                  miscompares++;
                  $display("FAIL %s_settle%0d got=%0d want=%0d", name, steps, gap,
                           (steps == 0) ? settle_t + 1 : settle_t);
               end
            end
            if (bus.Fout && !prev_fout) edges++;
         end else if (bus.Busy) begin
            gap++;
         end
         last_edge = bus.Meas_en && bus.Fout && !prev_fout;
         prev_fout = bus.Fout;
         prev_meas = bus.Meas_en;
         // Inputs scrambled while busy must not disturb the latched sweep.
         bus.Sel_start = 4'($urandom);
         bus.Sel_stop  = 4'($urandom);
         bus.Settle    = 8'($urandom);
         bus.Meas      = 8'($urandom);
         bus.Start     = bus.Done ? 1'b0 : 1'($urandom_range(0, 1));
      end
      bus.Start = 1'b0;

      vectors++;
      if (bus.Done !== 1'b1 || bus.Busy !== 1'b0 || steps != exp_q.size() ||
          divlow != exp_q.size() || int'(bus.Fsel) != exp_q[exp_q.size()-1]) begin
         miscompares++;
         $display("FAIL %s_end got done=%b busy=%b steps=%0d divlow=%0d fsel=%0d want done=1 busy=0 steps=%0d divlow=%0d fsel=%0d",
                  name, bus.Done, bus.Busy, steps, divlow, bus.Fsel, exp_q.size(), exp_q.size(),
                  exp_q[exp_q.size()-1]);
      end
      repeat (3) @(negedge Clk);
      vectors++;
      if (bus.Done !== 1'b1 || int'(bus.Fsel) != exp_q[exp_q.size()-1]) begin
         miscompares++;
         $display("FAIL %s_hold got done=%b fsel=%0d want done=1 fsel=%0d", name, bus.Done,
                  bus.Fsel, exp_q[exp_q.size()-1]);
      end
   endtask

   task automatic test_abort();
      int budget = 0;
      int bad = 0;
      @(negedge Clk);
      bus.Sel_start = 4'd1;
      bus.Sel_stop  = 4'd4;
      bus.Settle    = 8'd2;
      bus.Meas      = 8'd3;
      bus.Start     = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
      while (!(bus.Meas_en && bus.Fsel == 4'd2) && budget < 2000) begin
         @(negedge Clk);
         budget++;
      end
      vectors++;
      if (budget >= 2000) begin
         miscompares++;
         $display("FAIL abort_reach_measure got=timeout want=measure at fsel 2");
      end
      bus.Abort = 1'b1;
      @(negedge Clk);
      bus.Abort = 1'b0;
      vectors++;
      if ({bus.Busy, bus.Meas_en, bus.Step_done, bus.Done, bus.Fsel} !== {4'b0000, 4'd2}) begin
         miscompares++;
         $display("FAIL abort_next got busy/meas/step/done/fsel=%b want=%b",
                  {bus.Busy, bus.Meas_en, bus.Step_done, bus.Done, bus.Fsel}, {4'b0000, 4'd2});
      end
      repeat (6) begin
         @(negedge Clk);
         if (bus.Step_done || bus.Busy || bus.Fsel != 4'd2) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL abort_idle_quiet got=%0d bad cycles want=0", bad);
      end
      bus.Start = 1'b1;
      bus.Abort = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
      bus.Abort = 1'b0;
      vectors++;
      if (bus.Busy !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_over_start got busy=%b want=0", bus.Busy);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge Clk);
      bus.Sel_start = 4'd2;
      bus.Sel_stop  = 4'd3;
      bus.Settle    = 8'd30;
      bus.Meas      = 8'd1;
      bus.Start     = 1'b1;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (5) @(negedge Clk);
      Resetn = 1'b0;
      #1;
      vectors++;
      if ({bus.Fsel, bus.Div_resetn, bus.Meas_en, bus.Step_done, bus.Busy, bus.Done} !== 9'd0) begin
         miscompares++;
         $display("FAIL midreset_outputs got=%b want=0", {bus.Fsel, bus.Div_resetn, bus.Meas_en,
                  bus.Step_done, bus.Busy, bus.Done});
      end
      repeat (2) @(negedge Clk);
      Resetn = 1'b1;
      @(negedge Clk);
      vectors++;
      if ({bus.Div_resetn, bus.Busy, bus.Step_done} !== 3'b100) begin
         miscompares++;
         $display("FAIL midreset_release got divrst/busy/step=%b want=100",
                  {bus.Div_resetn, bus.Busy, bus.Step_done});
      end
      test_sweep("post_reset", 2, 3, 3, 2);
   endtask

   task automatic test_random();
      for (int n = 0; n < 6; n++) begin
         test_sweep($sformatf("rand%0d", n), $urandom_range(0, 5), $urandom_range(0, 5),
                    $urandom_range(0, 6), $urandom_range(0, 3));
      end
   endtask

   initial begin
      test_reset();
      test_sweep("basic", 1, 3, 4, 2);
      test_sweep("single", 5, 5, 4, 1);
      test_abort();
      test_sweep("top_end", 14, 15, 1, 1);
      test_sweep("low_end", 0, 1, 0, 0);
      test_sweep("descend", 4, 2, 3, 2);
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
